// File: rtl/fnd_scan_driver_pkg.sv
// Shared definitions for the 8-digit 7-segment scan driver.
// A 7-bit segment code is ordered {g,f,e,d,c,b,a}, where bit 0 is segment a.
// The board-level fnd bus adds the decimal point above it: {dp,g,f,e,d,c,b,a}.
package fnd_scan_driver_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEG_W      = 7;

  // Bit position of each segment inside a 7-bit segment code.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;

  localparam seg_t SEG_HEX_0 = 7'h3F;
  localparam seg_t SEG_HEX_1 = 7'h06;
  localparam seg_t SEG_HEX_2 = 7'h5B;
  localparam seg_t SEG_HEX_3 = 7'h4F;
  localparam seg_t SEG_HEX_4 = 7'h66;
  localparam seg_t SEG_HEX_5 = 7'h6D;
  localparam seg_t SEG_HEX_6 = 7'h7D;
  localparam seg_t SEG_HEX_7 = 7'h07;
  localparam seg_t SEG_HEX_8 = 7'h7F;
  localparam seg_t SEG_HEX_9 = 7'h6F;
  localparam seg_t SEG_HEX_A = 7'h77;
  localparam seg_t SEG_HEX_B = 7'h7C;
  localparam seg_t SEG_HEX_C = 7'h39;
  localparam seg_t SEG_HEX_D = 7'h5E;
  localparam seg_t SEG_HEX_E = 7'h79;
  localparam seg_t SEG_HEX_F = 7'h71;

endpackage

// File: rtl/fnd_scan_driver_hex_to_seg.sv
// Combinational hex nibble to 7-segment code, ordered {g,f,e,d,c,b,a}.
module hex_to_seg
  import fnd_scan_driver_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg_t       seg_o
);

  // One lookup per nibble value; the letters b and d are shown in lower case.
  always_comb begin
    seg_o = SEG_BLANK;
    unique case (nib_i)
      4'h0: seg_o = SEG_HEX_0;
      4'h1: seg_o = SEG_HEX_1;
      4'h2: seg_o = SEG_HEX_2;
      4'h3: seg_o = SEG_HEX_3;
      4'h4: seg_o = SEG_HEX_4;
      4'h5: seg_o = SEG_HEX_5;
      4'h6: seg_o = SEG_HEX_6;
      4'h7: seg_o = SEG_HEX_7;
      4'h8: seg_o = SEG_HEX_8;
      4'h9: seg_o = SEG_HEX_9;
      4'hA: seg_o = SEG_HEX_A;
      4'hB: seg_o = SEG_HEX_B;
      4'hC: seg_o = SEG_HEX_C;
      4'hD: seg_o = SEG_HEX_D;
      4'hE: seg_o = SEG_HEX_E;
      4'hF: seg_o = SEG_HEX_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/fnd_scan_driver.sv
// Time-multiplexed 8-digit 7-segment driver. It snapshots a 32-bit word on a
// load strobe and scans one digit per SCAN_DIV-cycle slot. The first GUARD
// cycles of each slot are dark, so the previous digit's segments cannot ghost
// onto the next one. All outputs are registered, with one cycle of latency
// from (cnt, idx, shadow).
module fnd_scan_driver
  import fnd_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic        lz_blank,
  output logic [7:0]  digit,
  output logic [7:0]  fnd,
  output logic        frame_done
);

  localparam int             CW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  GUARD_C  = CW'(GUARD);

  // Stop elaboration when the slot cannot hold a lit cycle.
  if (SCAN_DIV < 2 || GUARD < 0 || GUARD >= SCAN_DIV) begin : g_param_check
    $error("fnd_scan_driver: need SCAN_DIV >= 2 and 0 <= GUARD < SCAN_DIV");
  end

  logic [31:0]   shadow_data_q;
  logic [7:0]    shadow_dp_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    digit_q;
  logic [7:0]    fnd_q;
  logic          frame_done_q;

  logic          slot_end;
  logic [3:0]    cur_nib;
  seg_t          cur_seg;
  logic [7:0]    upper_zero;
  logic          lz_hide;
  logic [7:0]    digit_d;
  logic [7:0]    fnd_d;

  assign slot_end = (cnt_q == CNT_LAST);
  assign cur_nib  = shadow_data_q[{idx_q, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nib_i (cur_nib),
    .seg_o (cur_seg)
  );

  // upper_zero[i] is set when nibbles 7..i of the snapshot are all zero.
  always_comb begin
    upper_zero = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      upper_zero[i] = ((shadow_data_q >> (4 * i)) == 32'h0);
    end
  end

  // The leading-zero check reads lz_blank directly rather than from the
  // snapshot. Digit 0 always shows, so a zero value still displays "0".
  assign lz_hide = lz_blank && (idx_q != 3'd0) && upper_zero[idx_q];

  // Next output: dark during the guard, otherwise the selected digit. The dp
  // bit still shows on a blanked leading zero.
  always_comb begin
    digit_d = 8'h00;
    fnd_d   = 8'h00;
    if (cnt_q >= GUARD_C) begin
      digit_d = 8'(1) << idx_q;
      fnd_d   = {shadow_dp_q[idx_q], lz_hide ? SEG_BLANK : cur_seg};
    end
  end

  // Snapshot register. A load is ignored while reset is asserted, and the
  // last of several back-to-back loads is the one kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
    end else if (load) begin
      shadow_data_q <= data_in;
      shadow_dp_q   <= dp_in;
    end
  end

  // Slot counter and digit index. A load never restarts the slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (slot_end) begin
      cnt_q <= '0;
      idx_q <= idx_q + 3'd1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Registered pin drivers. frame_done marks the edge where idx wraps from 7 to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q      <= '0;
      fnd_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      digit_q      <= digit_d;
      fnd_q        <= fnd_d;
      frame_done_q <= slot_end && (idx_q == 3'd7);
    end
  end

  assign digit      = digit_q;
  assign fnd        = fnd_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Scoreboard bench for fnd_scan_driver with SCAN_DIV=4 and GUARD=1. The
// stimulus pushes one expected {digit,fnd,frame_done} per upcoming clock
// edge. The monitor pops one entry after every edge and compares it.
module tb_fnd_scan_driver;

  typedef struct {
    logic [7:0] d;
    logic [7:0] f;
    logic       fd;
    string      tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic        lz_blank;
  logic [7:0]  digit;
  logic [7:0]  fnd;
  logic        frame_done;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  exp_t m;
  logic [7:0] fr[8];

  always #5 clk = ~clk;

  fnd_scan_driver #(.SCAN_DIV(4), .GUARD(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .lz_blank   (lz_blank),
    .digit      (digit),
    .fnd        (fnd),
    .frame_done (frame_done)
  );

  // Monitor: one expectation per clock edge while the queue holds entries.
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      m = q.pop_front();
      checks++;
      if (digit !== m.d || fnd !== m.f || frame_done !== m.fd) begin
        errors++;
        $display("FAIL %s: got digit=%h fnd=%h fd=%b, want digit=%h fnd=%h fd=%b",
                 m.tag, digit, fnd, frame_done, m.d, m.f, m.fd);
      end
    end
  end

  task automatic push(input logic [7:0] d, input logic [7:0] f, input logic fd,
                      input string tag);
    exp_t e;
    e.d = d; e.f = f; e.fd = fd; e.tag = tag;
    q.push_back(e);
  endtask

  // One slot: a guard cycle, then three lit cycles. frame_done is set on the
  // last cycle of digit 7.
  task automatic push_slot(input int i, input logic [7:0] f0, input logic [7:0] f1,
                           input logic [7:0] f2, input string tag);
    logic [7:0] d;
    d = 8'(1) << i;
    push(8'h00, 8'h00, 1'b0, tag);
    push(d, f0, 1'b0, tag);
    push(d, f1, 1'b0, tag);
    push(d, f2, (i == 7), tag);
  endtask

  task automatic push_frame(input logic [7:0] f[8], input string tag);
    for (int i = 0; i < 8; i++) push_slot(i, f[i], f[i], f[i], tag);
  endtask

  // Wait until the monitor has drained the queue. Returns on a negedge.
  task automatic wait_empty(input int lim);
    bit done;
    done = 1'b0;
    for (int k = 0; k < lim && !done; k++) begin
      @(negedge clk);
      if (q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL timeout: %0d expectations left, want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; data_in = '0; dp_in = '0; lz_blank = 1'b0;
    repeat (2) @(negedge clk);

    // Outputs are held at zero while reset is asserted.
    push(8'h00, 8'h00, 1'b0, "reset_state");
    wait_empty(4);

    // Hex decode of every digit. frame_done pulses once per 32 cycles.
    reset = 1'b0; load = 1'b1; data_in = 32'h1234ABCD; dp_in = 8'h00;
    fr = '{8'h5E, 8'h39, 8'h7C, 8'h77, 8'h66, 8'h4F, 8'h5B, 8'h06};
    push_frame(fr, "hex_frame1");
    push_frame(fr, "hex_frame2");
    @(negedge clk); load = 1'b0;
    wait_empty(100);

    // Leading-zero blanking: digits 7..2 are dark but still selected.
    load = 1'b1; data_in = 32'h00000050; lz_blank = 1'b1;
    fr = '{8'h3F, 8'h6D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    push_frame(fr, "lz_on");
    @(negedge clk); load = 1'b0;
    wait_empty(50);

    // lz_blank is live: with no reload, the zeros show again.
    lz_blank = 1'b0;
    fr = '{8'h3F, 8'h6D, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
    push_frame(fr, "lz_off");
    wait_empty(50);

    // All zero with dp on digit 0: digit 0 keeps "0.", the rest are blank.
    load = 1'b1; data_in = 32'h0; dp_in = 8'h01; lz_blank = 1'b1;
    fr = '{8'hBF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    push_frame(fr, "zero_dp");
    @(negedge clk); load = 1'b0;
    wait_empty(50);

    // Load 0xFFFFFFFF mid-slot on digit 3. The new value shows one cycle
    // after the load edge, and the scan timing is undisturbed.
    load = 1'b1; data_in = 32'h0; dp_in = 8'h00; lz_blank = 1'b0;
    for (int i = 0; i < 3; i++) push_slot(i, 8'h3F, 8'h3F, 8'h3F, "midload_pre");
    push_slot(3, 8'h3F, 8'h3F, 8'h71, "midload_d3");
    for (int i = 4; i < 8; i++) push_slot(i, 8'h71, 8'h71, 8'h71, "midload_post");
    @(negedge clk); load = 1'b0;
    repeat (13) @(negedge clk);
    load = 1'b1; data_in = 32'hFFFFFFFF;
    @(negedge clk); load = 1'b0;
    wait_empty(50);

    // A one-cycle reset on digit 5 clears the snapshot; a load during reset is
    // dropped. The scan then restarts at digit 0 with a guard cycle.
    for (int i = 0; i < 5; i++) push_slot(i, 8'h71, 8'h71, 8'h71, "rst_pre");
    push(8'h00, 8'h00, 1'b0, "rst_d5_guard");
    push(8'h20, 8'h71, 1'b0, "rst_d5_lit");
    push(8'h00, 8'h00, 1'b0, "rst_edge");
    fr = '{8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
    push_frame(fr, "rst_after");
    repeat (22) @(negedge clk);
    reset = 1'b1; load = 1'b1; data_in = 32'h99999999; dp_in = 8'hFF;
    @(negedge clk); reset = 1'b0; load = 1'b0; dp_in = 8'h00;
    wait_empty(80);

    // Back-to-back loads: the second one wins from the edge after it.
    load = 1'b1; data_in = 32'h11111111;
    push_slot(0, 8'h06, 8'h5B, 8'h5B, "b2b_d0");
    for (int i = 1; i < 8; i++) push_slot(i, 8'h5B, 8'h5B, 8'h5B, "b2b");
    @(negedge clk); data_in = 32'h22222222;
    @(negedge clk); load = 1'b0;
    wait_empty(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
